// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use stall, branch flush and
// a data-memory wait FSM that freezes the pipeline and flags a sticky timeout.
module hazard_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_rs1_d,
  input  logic [4:0] i_rs2_d,
  input  logic [4:0] i_rd_d,
  input  logic       i_reg_write_d,
  input  logic [1:0] i_result_src_d,
  input  logic       i_pc_src_e,
  input  logic       i_dmem_req_m,
  input  logic       i_dmem_ack,
  output logic [1:0] o_forward_a_e,
  output logic [1:0] o_forward_b_e,
  output logic       o_stall_f,
  output logic       o_stall_d,
  output logic       o_flush_d,
  output logic       o_flush_e,
  output logic       o_freeze,
  output logic       o_mem_timeout
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} wait_state_t;

  logic [4:0]  e_rs1_r, e_rs2_r, e_rd_r, m_rd_r, w_rd_r;
  logic        e_wr_r, e_ld_r, m_wr_r, w_wr_r;
  wait_state_t state_r;
  logic [7:0]  cnt_r;
  logic        timeout_r;

  logic [1:0]  fwd_a_s, fwd_b_s;
  logic        lu_s, freeze_s, taken_s, flush_e_s;
  logic [7:0]  cnt_inc_s;

  // The newer writer in MEM wins over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic m_wr, input logic [4:0] m_rd,
                                         input logic w_wr, input logic [4:0] w_rd);
    if (m_wr && (m_rd != 5'd0) && (m_rd == rs)) begin
      return 2'b10;
    end else if (w_wr && (w_rd != 5'd0) && (w_rd == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Hazard decisions from shadow state and decode-stage inputs.
  always_comb begin
    fwd_a_s   = fwd_sel(e_rs1_r, m_wr_r, m_rd_r, w_wr_r, w_rd_r);
    fwd_b_s   = fwd_sel(e_rs2_r, m_wr_r, m_rd_r, w_wr_r, w_rd_r);
    lu_s      = e_ld_r && (e_rd_r != 5'd0) &&
                ((e_rd_r == i_rs1_d) || (e_rd_r == i_rs2_d));
    freeze_s  = i_dmem_req_m && !i_dmem_ack;
    // Gated by reset so stall/flush outputs stay low while reset is held.
    taken_s   = i_pc_src_e && i_rst_n;
    flush_e_s = (lu_s || taken_s) && !freeze_s;
    cnt_inc_s = (cnt_r == 8'hFF) ? 8'hFF : (cnt_r + 8'd1);
  end

  assign o_forward_a_e = fwd_a_s;
  assign o_forward_b_e = fwd_b_s;
  assign o_stall_f     = lu_s && !taken_s && !freeze_s;
  assign o_stall_d     = lu_s && !taken_s && !freeze_s;
  assign o_flush_d     = taken_s && !freeze_s;
  assign o_flush_e     = flush_e_s;
  assign o_freeze      = freeze_s;
  assign o_mem_timeout = timeout_r;

  // Shadow pipeline advance; a flushed EX slot becomes an all-zero bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_rs1_r <= 5'd0; e_rs2_r <= 5'd0; e_rd_r <= 5'd0; e_wr_r <= 1'b0; e_ld_r <= 1'b0;
      m_rd_r  <= 5'd0; m_wr_r  <= 1'b0;
      w_rd_r  <= 5'd0; w_wr_r  <= 1'b0;
    end else if (!freeze_s) begin
      w_rd_r <= m_rd_r;
      w_wr_r <= m_wr_r;
      m_rd_r <= e_rd_r;
      m_wr_r <= e_wr_r;
      if (flush_e_s) begin
        e_rs1_r <= 5'd0; e_rs2_r <= 5'd0; e_rd_r <= 5'd0; e_wr_r <= 1'b0; e_ld_r <= 1'b0;
      end else begin
        e_rs1_r <= i_rs1_d;
        e_rs2_r <= i_rs2_d;
        e_rd_r  <= i_rd_d;
        e_wr_r  <= i_reg_write_d;
        e_ld_r  <= (i_result_src_d == 2'b01);
      end
    end
  end

  // Memory-wait FSM with saturating wait counter and sticky timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r   <= 8'd0;
          state_r <= freeze_s ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          cnt_r <= cnt_inc_s;
          if (cnt_inc_s == LIMIT) begin
            timeout_r <= 1'b1;
          end
          state_r <= freeze_s ? ST_WAIT : ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit against a stage-list reference model.
`timescale 1ns/1ps
module tb_hazard_unit;

  localparam int LIMIT = 4;
  localparam int NCYC  = 450;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       reg_write_d;
  logic [1:0] result_src_d;
  logic       pc_src_e, dmem_req_m, dmem_ack;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e, freeze, mem_timeout;

  hazard_unit #(.WAIT_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rd_d(rd_d),
    .i_reg_write_d(reg_write_d), .i_result_src_d(result_src_d),
    .i_pc_src_e(pc_src_e), .i_dmem_req_m(dmem_req_m), .i_dmem_ack(dmem_ack),
    .o_forward_a_e(forward_a_e), .o_forward_b_e(forward_b_e),
    .o_stall_f(stall_f), .o_stall_d(stall_d),
    .o_flush_d(flush_d), .o_flush_e(flush_e),
    .o_freeze(freeze), .o_mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       wr, ld;
  } stage_t;

  // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
  stage_t pipe [3];
  stage_t d_now;
  bit     frz_now, fe_now, last_frz, tmo;
  int     wait_cycles;

  logic [9:0] exp_q [$];
  bit         done = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    for (int i = 1; i <= 2; i++) begin
      if (pipe[i].wr && pipe[i].rd != 5'd0 && pipe[i].rd == rs)
        return (i == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    tmo = 1'b0; wait_cycles = 0; last_frz = 1'b0;
  endtask

  task automatic model_edge();
    if (!frz_now) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = fe_now ? stage_t'('0) : d_now;
    end
    // A cycle is a wait-state cycle exactly when the cycle before it was frozen.
    if (last_frz) begin
      wait_cycles++;
      if (wait_cycles >= LIMIT) tmo = 1'b1;
    end else begin
      wait_cycles = 0;
    end
    last_frz = frz_now;
  endtask

  function automatic logic [9:0] model_expect();
    bit lu, taken, stall;
    lu      = pipe[0].ld && pipe[0].rd != 5'd0 && (pipe[0].rd == rs1_d || pipe[0].rd == rs2_d);
    frz_now = dmem_req_m && !dmem_ack;
    taken   = pc_src_e && rst_n;
    stall   = lu && !taken && !frz_now;
    fe_now  = (lu || taken) && !frz_now;
    d_now   = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d, wr: reg_write_d, ld: (result_src_d == 2'b01)};
    return {model_fwd(pipe[0].rs1), model_fwd(pipe[0].rs2), stall, stall,
            taken && !frz_now, fe_now, frz_now, tmo};
  endfunction

  // Stimulus: model advances at each edge, then new inputs and expectation are issued.
  initial begin
    rst_n = 1'b0; rs1_d = '0; rs2_d = '0; rd_d = '0; reg_write_d = 1'b0;
    result_src_d = 2'b00; pc_src_e = 1'b0; dmem_req_m = 1'b0; dmem_ack = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      rst_n = !(cyc < 2 || (cyc >= 200 && cyc < 203) || (cyc >= 330 && cyc < 332));
      if (!rst_n) model_reset();
      rs1_d        = 5'($urandom_range(0, 7));
      rs2_d        = 5'($urandom_range(0, 7));
      rd_d         = 5'($urandom_range(0, 7));
      reg_write_d  = 1'($urandom_range(0, 3) != 0);
      result_src_d = 2'($urandom_range(0, 3));
      pc_src_e     = 1'($urandom_range(0, 6) == 0);
      if (cyc >= 100 && cyc < 108) begin
        dmem_req_m = 1'b1; dmem_ack = 1'b0;           // long withheld ack
      end else if (cyc >= 140 && cyc < 200) begin
        dmem_req_m = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 4) == 0);
      end else if (cyc >= 332 && cyc < 400) begin
        dmem_req_m = 1'b0; dmem_ack = 1'b0;           // no memory traffic: timeout must stay low
      end else begin
        dmem_req_m = 1'($urandom_range(0, 2) == 0); dmem_ack = 1'($urandom_range(0, 1));
      end
      exp_q.push_back(model_expect());
    end
    @(posedge clk);
    done = 1'b1;
  end

  // Monitor: pops one expectation per cycle and compares away from the active edge.
  initial begin
    logic [9:0] exp_v, act_v;
    int guard = 0;
    while (!(done && exp_q.size() == 0)) begin
      @(negedge clk);
      guard++;
      if (guard > NCYC + 100) begin
        miscompares++;
        $display("FAIL timeout: monitor exceeded cycle budget, %0d expectations pending", exp_q.size());
        break;
      end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e, freeze, mem_timeout};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs vec %0d t=%0t: got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b frz=%b tmo=%b, want fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b frz=%b tmo=%b",
                   vectors, $time, act_v[9:8], act_v[7:6], act_v[5], act_v[4], act_v[3], act_v[2], act_v[1], act_v[0],
                   exp_v[9:8], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: WAIT_LIMIT, default 255, data-memory wait cycles before the timeout error is flagged (range 1..255).
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_rs1_d, i_rs2_d  input  5 each  decode-stage source register indices.
REQ-005 i_rd_d  input  5  decode-stage destination register index.
REQ-006 i_reg_write_d  input  1  decode-stage instruction writes rd.
REQ-007 i_result_src_d  input  2  decode-stage result source; 2'b01 = load.
REQ-008 i_pc_src_e  input  1  branch/jump taken, resolved in EX.
REQ-009 i_dmem_req_m  input  1  MEM-stage data-memory request pending.
REQ-010 i_dmem_ack  input  1  data-memory response accepted this cycle.
REQ-011 o_forward_a_e, o_forward_b_e  output  2 each  EX operand selects: 2'b00 register file, 2'b01 WB result, 2'b10 MEM ALU result; 2'b11 never driven.
REQ-012 o_stall_f, o_stall_d  output  1 each  hold PC / IF-ID register.
REQ-013 o_flush_d, o_flush_e  output  1 each  clear IF-ID / ID-EX register to a bubble.
REQ-014 o_freeze  output  1  hold every pipeline register (memory wait).
REQ-015 o_mem_timeout  output  1  sticky wait-timeout error.

Function
REQ-016 Shadow pipeline state: E stage {rs1, rs2, rd, reg_write, is_load}, M stage {rd, reg_write}, W stage {rd, reg_write}.
REQ-017 When o_freeze=0: W<=M, M<=E, E<=D inputs; E loads a bubble (all fields zero) when o_flush_e=1.
REQ-018 When o_freeze=1: all shadow state holds.
REQ-019 Forward A: 2'b10 if M.reg_write and M.rd!=0 and M.rd==E.rs1; else 2'b01 if W.reg_write and W.rd!=0 and W.rd==E.rs1; else 2'b00 (same rule for B with E.rs2).
REQ-020 Forward outputs are combinational from registered shadow state; M priority over W; x0 is never forwarded.
REQ-021 Load-use: lu = E.is_load and E.rd!=0 and (E.rd==i_rs1_d or E.rd==i_rs2_d).
REQ-022 o_stall_f = o_stall_d = lu and !i_pc_src_e and !o_freeze.
REQ-023 o_flush_d = i_pc_src_e and !o_freeze; o_flush_e = (lu or i_pc_src_e) and !o_freeze.
REQ-024 Branch taken with simultaneous load-use: branch wins -- flush D and E, no stall.
REQ-025 Wait FSM states IDLE, WAIT; o_freeze = i_dmem_req_m and !i_dmem_ack (combinational, in either state).
REQ-026 IDLE->WAIT when i_dmem_req_m=1 and i_dmem_ack=0; WAIT->IDLE when i_dmem_ack=1 or i_dmem_req_m=0.
REQ-027 8-bit wait counter: cleared in IDLE, increments each WAIT cycle, saturates at 255.
REQ-028 o_mem_timeout set on the edge where the counter reaches WAIT_LIMIT in WAIT; sticky until reset; does not alter freeze.
REQ-029 Ack in the same cycle as request: no freeze, FSM stays IDLE, zero latency.

Reset
REQ-030 On i_rst_n=0, asynchronously: all shadow fields 0, FSM IDLE, counter 0, o_mem_timeout 0.
REQ-031 During reset all outputs are 0 provided i_dmem_req_m=0; reset mid-WAIT returns FSM to IDLE immediately.
REQ-032 First active edge after deassertion treated as normal cycle.

Verification
REQ-033 ALU x5 in E, next instr rs1=5 -> following cycle o_forward_a_e=2'b10; one cycle later 2'b01 if no newer writer.
REQ-034 Writers to x5 in both M and W, E.rs2=5 -> o_forward_b_e=2'b10; rd=0 writers -> 2'b00.
REQ-035 Load to x7 in E, D rs2=7 -> o_stall_f=o_stall_d=o_flush_e=1 for one cycle, then o_forward_b_e=2'b01 after the load reaches W.
REQ-036 Load-use plus i_pc_src_e=1 same cycle -> o_flush_d=o_flush_e=1, stalls 0.
REQ-037 i_dmem_req_m=1, ack held low 3 cycles -> o_freeze=1 for those 3 cycles, shadow state unchanged, forward selects stable; ack -> freeze drops same cycle.
REQ-038 WAIT_LIMIT=4, ack withheld 6 cycles -> o_mem_timeout rises after 4th WAIT cycle, stays 1 after ack, cleared only by i_rst_n=0.
